word_index_counter: RTL and testbench
=====================================

WORD_INDEX_COUNTER -- requirements
Module: word_index_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter/limit width, legal range 2..16.
REQ-002 Parameter STEP_W, default 2, step-amount width, legal range 1..WIDTH.
REQ-003 clk_i  input  1  single clock, rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  begin a run; accepted in IDLE, or in DONE together with ack_i.
REQ-006 limit_i  input  WIDTH  terminal index, sampled on accepted start.
REQ-007 mode_i  input  1  sampled on accepted start; 0 = wrap, 1 = saturate.
REQ-008 clear_i  input  1  synchronous abort: count 0, go to IDLE.
REQ-009 step_en_i  input  1  advance the counter by step_i this cycle.
REQ-010 step_i  input  STEP_W  increment amount; 0 is legal.
REQ-011 ack_i  input  1  acknowledge done, leaves DONE.
REQ-012 count_o  output  WIDTH  current index, registered.
REQ-013 busy_o  output  1  high in RUN.
REQ-014 done_o  output  1  high in DONE.
REQ-015 last_o  output  1  count_o equals latched limit while in RUN; decoded from registers only.
REQ-016 wrap_o  output  1  one-cycle pulse in the cycle after a wrap.
REQ-017 sat_o  output  1  sticky; saturate-mode step overshot the limit.
REQ-018 err_o  output  1  sticky; wrap-mode step exceeded one full period.

Function
REQ-019 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-020 Priority SHALL be clear_i > start_i/ack_i > step_en_i.
REQ-021 clear_i in any state SHALL set count 0, state IDLE, clear sat_o/err_o next edge.
REQ-022 IDLE: start_i SHALL set count 0, latch limit_i/mode_i, clear sat_o/err_o, enter RUN next cycle; step_en_i ignored.
REQ-023 RUN: on step_en_i, sum = count + step_i SHALL be computed at WIDTH+1 bits with no truncation.
REQ-024 RUN, sum <= limit: count SHALL become sum; state stays RUN.
REQ-025 Saturate mode, sum >= limit: count SHALL become limit and state SHALL become DONE; sat_o SHALL set if sum > limit.
REQ-026 Wrap mode, sum > limit: count SHALL become sum-(limit+1), wrap_o SHALL pulse, state stays RUN; wrap mode never enters DONE.
REQ-027 Wrap mode, sum-(limit+1) > limit: count SHALL become limit, err_o SHALL set, wrap_o SHALL pulse.
REQ-028 step_en_i with step_i = 0 SHALL leave count unchanged, except in saturate mode with count = limit, which SHALL enter DONE.
REQ-029 limit = 0: saturate SHALL enter DONE on first step_en_i; wrap SHALL hold 0 and pulse wrap_o on each non-zero step.
REQ-030 start_i in RUN SHALL be ignored; start_i in DONE without ack_i SHALL be ignored.
REQ-031 DONE: count SHALL hold; ack_i SHALL go to IDLE; ack_i with start_i SHALL restart directly into RUN per REQ-022.
REQ-032 Every state change and count update SHALL take effect one clock after the causing input; there is no combinational input-to-output path.

Reset
REQ-033 rst_ni low SHALL immediately, without a clock edge, set state IDLE, count_o 0, latched limit 0, mode 0, and busy_o/done_o/wrap_o/sat_o/err_o 0.
REQ-034 Reset deassertion SHALL be synchronised by the integrator; the block SHALL operate from the first rising edge after deassertion.

Structure
REQ-035 Shared package word_counter_pkg SHALL hold the state enum and the MODE_WRAP/MODE_SAT constants.
REQ-036 Step arithmetic SHALL be in a combinational sub-module word_step_unit: sum, compare, wrap subtract, overshoot flags.
REQ-037 The top SHALL hold only the FSM, the registers and the output decode.

Verification (WIDTH=4, STEP_W=2)
REQ-038 Saturate mode, limit=7, steps 2,2,2,2 -> count 2,4,6,7; sat_o=1, done_o=1, busy_o=0 after 4th step.
REQ-039 Wrap mode, limit=7, count=6, step 3 -> count 1, wrap_o high exactly one cycle, busy_o stays 1.
REQ-040 RUN with count=5, clear_i and step_en_i (step 2) in the same cycle -> count 0, IDLE, sat_o/err_o 0.
REQ-041 DONE, start_i with ack_i, limit_i=3 -> RUN next cycle, count 0, last_o 0; step 3 -> count 3, DONE.
REQ-042 Wrap mode, limit=0, step 3 -> count 0, err_o=1, wrap_o pulse.
REQ-043 rst_ni low between edges mid-RUN at count=9 -> all outputs 0 before the next clk_i edge.

Source files
------------

// File: rtl/word_counter_pkg.sv
// word_counter_pkg: shared FSM state encoding and run-mode constants.
//   state_t   : IDLE / RUN / DONE
//   MODE_WRAP : run wraps past the limit and never finishes
//   MODE_SAT  : run clamps at the limit and finishes there
package word_counter_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
endpackage

// File: rtl/word_step_unit.sv
// word_step_unit: combinational step arithmetic for one counter advance.
//   count, limit, step, mode : current index, latched limit, increment, latched mode
//   next_count               : index after the step
//   hit                      : saturate mode reached or passed the limit (finish run)
//   over                     : saturate mode overshot the limit
//   wrap                     : wrap mode passed the limit
//   bad                      : wrap mode overshot by more than one full period
module word_step_unit
  import word_counter_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 2
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [WIDTH-1:0]  limit,
  input  logic [STEP_W-1:0] step,
  input  logic              mode,
  output logic [WIDTH-1:0]  next_count,
  output logic              hit,
  output logic              over,
  output logic              wrap,
  output logic              bad
);
  logic [WIDTH:0] sum, lim, rem;
  logic sat_m, ge, gt;
  // One extra bit keeps the sum and limit+1 exact, so no compare sees a truncated value.
  assign sum   = {1'b0, count} + {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign lim   = {1'b0, limit};
  assign rem   = sum - (lim + 1'b1);
  assign sat_m = mode == MODE_SAT;
  assign ge    = sum >= lim;
  assign gt    = sum > lim;
  assign hit   = sat_m && ge;
  assign over  = sat_m && gt;
  assign wrap  = !sat_m && gt;
  assign bad   = wrap && rem > lim;
  assign next_count = (hit || bad) ? limit : wrap ? rem[WIDTH-1:0] : sum[WIDTH-1:0];
endmodule

// File: rtl/word_index_counter.sv
// word_index_counter: run-controlled index counter with wrap or saturate behaviour.
//   clk_i, rst_ni          : clock, async active-low reset
//   start_i, limit_i, mode_i : begin a run with terminal index and mode
//   clear_i                : synchronous abort to IDLE with count 0
//   step_en_i, step_i      : advance by step_i while running
//   ack_i                  : leave DONE (with start_i: restart straight into RUN)
//   count_o                : registered index
//   busy_o, done_o, last_o : RUN, DONE, RUN at the limit
//   wrap_o, sat_o, err_o   : wrap pulse, sticky overshoot, sticky over-period wrap
module word_index_counter
  import word_counter_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [WIDTH-1:0]  limit_i,
  input  logic              mode_i,
  input  logic              clear_i,
  input  logic              step_en_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              ack_i,
  output logic [WIDTH-1:0]  count_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              last_o,
  output logic              wrap_o,
  output logic              sat_o,
  output logic              err_o
);
  state_t state;
  logic [WIDTH-1:0] count_q, limit_q, next_count;
  logic mode_q, wrap_q, sat_q, err_q, hit, over, wrap, bad, accept;
  word_step_unit #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_step (
    .count(count_q),
    .limit(limit_q),
    .step(step_i),
    .mode(mode_q),
    .next_count(next_count),
    .hit(hit),
    .over(over),
    .wrap(wrap),
    .bad(bad)
  );
  // A start is only taken from IDLE, or from DONE when it comes with its acknowledge.
  assign accept = start_i && (state == IDLE || (state == DONE && ack_i));
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      count_q <= '0;
      limit_q <= '0;
      mode_q  <= MODE_WRAP;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else if (clear_i) begin
      state   <= IDLE;
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (accept) begin
        state   <= RUN;
        count_q <= '0;
        limit_q <= limit_i;
        mode_q  <= mode_i;
        sat_q   <= 1'b0;
        err_q   <= 1'b0;
      end else if (state == DONE && ack_i) begin
        state <= IDLE;
      end else if (state == RUN && step_en_i) begin
        count_q <= next_count;
        wrap_q  <= wrap;
        sat_q   <= sat_q | over;
        err_q   <= err_q | bad;
        if (hit) state <= DONE;
      end
    end
  end
  assign count_o = count_q;
  assign busy_o  = state == RUN;
  assign done_o  = state == DONE;
  assign last_o  = state == RUN && count_q == limit_q;
  assign wrap_o  = wrap_q;
  assign sat_o   = sat_q;
  assign err_o   = err_q;
endmodule

// File: tb/tb_word_index_counter.sv
// tb_word_index_counter: directed self-checking bench for word_index_counter (WIDTH=4, STEP_W=2).
module tb_word_index_counter;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic start_i = 1'b0, mode_i = 1'b0, clear_i = 1'b0, step_en_i = 1'b0, ack_i = 1'b0;
  logic [3:0] limit_i = '0;
  logic [1:0] step_i = '0;
  logic [3:0] count_o;
  logic busy_o, done_o, last_o, wrap_o, sat_o, err_o;
  int checks = 0, errors = 0;
  word_index_counter #(.WIDTH(4), .STEP_W(2)) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .start_i(start_i),
    .limit_i(limit_i),
    .mode_i(mode_i),
    .clear_i(clear_i),
    .step_en_i(step_en_i),
    .step_i(step_i),
    .ack_i(ack_i),
    .count_o(count_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .last_o(last_o),
    .wrap_o(wrap_o),
    .sat_o(sat_o),
    .err_o(err_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic step(input logic [1:0] s);
    step_en_i = 1'b1;
    step_i = s;
    tick();
    step_en_i = 1'b0;
  endtask
  task automatic begin_run(input logic [3:0] lim, input logic m, input logic with_ack);
    start_i = 1'b1;
    ack_i = with_ack;
    limit_i = lim;
    mode_i = m;
    tick();
    start_i = 1'b0;
    ack_i = 1'b0;
  endtask
  initial begin
    #3;
    check("rst_count", count_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_flags", {wrap_o, sat_o, err_o, last_o}, 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    step_en_i = 1'b1;
    step_i = 2'd3;
    tick();
    step_en_i = 1'b0;
    check("idle_step_ignored", {busy_o, count_o}, 0);
    begin_run(4'd7, 1'b1, 1'b0);
    check("sat_start_busy", busy_o, 1);
    check("sat_start_count", count_o, 0);
    check("sat_start_last", last_o, 0);
    step(2'd2); check("sat_c2", count_o, 2);
    step(2'd2); check("sat_c4", count_o, 4);
    step(2'd2); check("sat_c6", count_o, 6);
    check("sat_c6_sat", sat_o, 0);
    step(2'd2); check("sat_c7", count_o, 7);
    check("sat_flag", sat_o, 1);
    check("sat_done", done_o, 1);
    check("sat_busy", busy_o, 0);
    begin_run(4'd2, 1'b0, 1'b0);
    check("done_start_noack", {done_o, busy_o, count_o}, {1'b1, 1'b0, 4'd7});
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    check("ack_idle", {done_o, busy_o}, 0);
    begin_run(4'd7, 1'b0, 1'b0);
    step(2'd3); check("wrap_c3", count_o, 3);
    step(2'd3); check("wrap_c6", count_o, 6);
    check("wrap_c6_pulse", wrap_o, 0);
    step(2'd3); check("wrap_c1", count_o, 1);
    check("wrap_pulse", wrap_o, 1);
    check("wrap_busy", busy_o, 1);
    tick();
    check("wrap_pulse_end", wrap_o, 0);
    check("wrap_hold", count_o, 1);
    step(2'd3); step(2'd3);
    check("wrap_c7", count_o, 7);
    check("wrap_last", last_o, 1);
    step(2'd0);
    check("wrap_step0", {count_o, busy_o, done_o, wrap_o}, {4'd7, 1'b1, 1'b0, 1'b0});
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    begin_run(4'd0, 1'b0, 1'b0);
    step(2'd3);
    check("lim0_count", count_o, 0);
    check("lim0_err", err_o, 1);
    check("lim0_wrap", wrap_o, 1);
    step(2'd1);
    check("lim0_s1", {count_o, wrap_o, err_o, busy_o}, {4'd0, 1'b1, 1'b1, 1'b1});
    begin_run(4'd5, 1'b0, 1'b0);
    check("run_start_ignored", {busy_o, last_o}, 2'b11);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clear_err", {err_o, busy_o, count_o}, 0);
    begin_run(4'd7, 1'b1, 1'b0);
    step(2'd3); step(2'd2);
    check("pre_clear_c5", count_o, 5);
    clear_i = 1'b1;
    step(2'd2);
    clear_i = 1'b0;
    check("clear_count", count_o, 0);
    check("clear_state", {busy_o, done_o}, 0);
    check("clear_flags", {sat_o, err_o}, 0);
    begin_run(4'd7, 1'b1, 1'b0);
    step(2'd3); step(2'd3); step(2'd3);
    check("pre_restart", {count_o, done_o, sat_o}, {4'd7, 1'b1, 1'b1});
    begin_run(4'd3, 1'b1, 1'b1);
    check("restart_busy", busy_o, 1);
    check("restart_count", count_o, 0);
    check("restart_last", last_o, 0);
    check("restart_sat", sat_o, 0);
    step(2'd3);
    check("restart_c3", count_o, 3);
    check("restart_done", done_o, 1);
    check("restart_nosat", sat_o, 0);
    begin_run(4'd0, 1'b1, 1'b1);
    step(2'd0);
    check("lim0_sat_done", {done_o, count_o, sat_o}, {1'b1, 4'd0, 1'b0});
    begin_run(4'd12, 1'b1, 1'b1);
    step(2'd3); step(2'd3); step(2'd3);
    check("pre_rst_c9", {count_o, busy_o}, {4'd9, 1'b1});
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_count", count_o, 0);
    check("async_rst_state", {busy_o, done_o, last_o}, 0);
    check("async_rst_flags", {wrap_o, sat_o, err_o}, 0);
    #1;
    rst_ni = 1'b1;
    tick();
    check("post_rst_idle", {busy_o, done_o, count_o}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
